ascon_perm_ctrl: RTL and testbench

ASCON_PERM_CTRL -- requirements
Module: ascon_perm_ctrl

---
 rtl/reg_pkg.sv | 72 +++++++
 rtl/asconp_lut.sv | 66 ++++++
 rtl/ascon_perm_ctrl.sv | 140 ++++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// Shared types and helpers for the Ascon permutation controller.
// Holds the state layout, modes, round limits and the S-box reset table.
package reg_pkg;

  localparam int MAX_ROUND = 12;

  localparam logic [3:0] ROUNDS_6  = 4'd6;
  localparam logic [3:0] ROUNDS_8  = 4'd8;
  localparam logic [3:0] ROUNDS_12 = 4'd12;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } state_t;

  typedef enum logic [1:0] {
    PM_PLAIN = 2'd0,
    PM_INIT  = 2'd1,
    PM_FINAL = 2'd2
  } perm_mode_t;

  typedef enum logic {
    FSM_IDLE = 1'b0,
    FSM_BUSY = 1'b1
  } fsm_e;

  typedef struct packed {
    logic       valid;
    logic       write;
    logic [7:0] addr;
    logic [4:0] wdata;
  } reg_req_t;

  typedef struct packed {
    logic       ready;
    logic       error;
    logic [7:0] rdata;
  } reg_rsp_t;

  localparam logic [4:0] SBOX_RST [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic legal_rounds(logic [3:0] n);
    return (n == ROUNDS_6) || (n == ROUNDS_8) || (n == ROUNDS_12);
  endfunction

  function automatic logic [63:0] ror64(logic [63:0] x, int unsigned s);
    return (x >> s) | (x << (64 - s));
  endfunction

  function automatic state_t lin_layer(state_t s);
    state_t r;
    r.x0 = s.x0 ^ ror64(s.x0, 19) ^ ror64(s.x0, 28);
    r.x1 = s.x1 ^ ror64(s.x1, 61) ^ ror64(s.x1, 39);
    r.x2 = s.x2 ^ ror64(s.x2, 1)  ^ ror64(s.x2, 6);
    r.x3 = s.x3 ^ ror64(s.x3, 10) ^ ror64(s.x3, 17);
    r.x4 = s.x4 ^ ror64(s.x4, 7)  ^ ror64(s.x4, 41);
    return r;
  endfunction

  function automatic logic [7:0] round_const(logic [3:0] r);
    return {4'hf - r, r};
  endfunction

endpackage

// File: rtl/asconp_lut.sv
// One Ascon round with a register-writable S-box table.
// Round indices of 12 and above pass the state through untouched.
module asconp_lut
  import reg_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  reg_req_t reg_req_i,
  output reg_rsp_t reg_rsp_o,
  input  logic [3:0] rnd_i,
  input  state_t   state_i,
  output state_t   state_o
);

  logic [4:0] lut_q [32];
  logic       addr_ok;
  logic       wr_en;
  logic [4:0] sb;
  state_t     add_st;
  state_t     sub_st;

  assign addr_ok = (reg_req_i.addr[7:5] == 3'd0);
  assign wr_en   = reg_req_i.valid && reg_req_i.write && addr_ok;

  // S-box table, reloaded with the Ascon S-box on reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 32; i++) begin
        lut_q[i] <= SBOX_RST[i];
      end
    end else if (wr_en) begin
      lut_q[reg_req_i.addr[4:0]] <= reg_req_i.wdata;
    end
  end

  // register read port, answers in the same cycle
  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    reg_rsp_o.error = reg_req_i.valid && !addr_ok;
    reg_rsp_o.rdata = {3'b000, lut_q[reg_req_i.addr[4:0]]};
  end

  // constant add, column-wise substitution, linear diffusion
  always_comb begin
    sb     = '0;
    add_st = state_i;
    add_st.x2[7:0] = state_i.x2[7:0] ^ round_const(rnd_i);
    sub_st = '0;
    for (int j = 0; j < 64; j++) begin
      sb = lut_q[{add_st.x0[j], add_st.x1[j], add_st.x2[j],
                  add_st.x3[j], add_st.x4[j]}];
      sub_st.x0[j] = sb[4];
      sub_st.x1[j] = sb[3];
      sub_st.x2[j] = sb[2];
      sub_st.x3[j] = sb[1];
      sub_st.x4[j] = sb[0];
    end
    if (rnd_i >= 4'(MAX_ROUND)) begin
      state_o = state_i;
    end else begin
      state_o = lin_layer(sub_st);
    end
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Ascon permutation controller: runs n rounds, UNROLL per clock,
// with optional key XOR on entry (FINAL) and exit (INIT/FINAL).
module ascon_perm_ctrl
  import reg_pkg::*;
#(
  parameter int   UNROLL     = 1,
  parameter logic IRQ_EN_RST = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  reg_req_t     sbox_reg_req_i,
  output reg_rsp_t     sbox_reg_rsp_o,
  input  logic         start_i,
  output logic         ready_o,
  input  logic [3:0]   rounds_i,
  input  perm_mode_t   mode_i,
  input  logic [127:0] key_i,
  input  logic         abort_i,
  input  logic         irq_en_i,
  input  state_t       state_i,
  output state_t       state_o,
  output logic         update_state_o,
  output logic         done_o,
  output logic         ascon_intr_o,
  output logic         err_o
);

  fsm_e         fsm_q;
  logic [3:0]   idx_q;
  perm_mode_t   mode_q;
  logic [127:0] key_q;
  state_t       work_q;
  logic         done_q;
  logic         err_q;
  logic         irq_en_q;

  state_t       stg [UNROLL+1];
  state_t       load_st;
  state_t       busy_st;
  logic [4:0]   idx_nx;
  logic         last;
  logic         busy;

  assign busy   = (fsm_q == FSM_BUSY);
  assign stg[0] = work_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_stage
    if (k == 0) begin : g_rsp
      asconp_lut u_lut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .reg_req_i (sbox_reg_req_i),
        .reg_rsp_o (sbox_reg_rsp_o),
        .rnd_i     (idx_q + 4'(k)),
        .state_i   (stg[k]),
        .state_o   (stg[k+1])
      );
    end else begin : g_nrsp
      reg_rsp_t rsp_unused;
      asconp_lut u_lut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .reg_req_i (sbox_reg_req_i),
        .reg_rsp_o (rsp_unused),
        .rnd_i     (idx_q + 4'(k)),
        .state_i   (stg[k]),
        .state_o   (stg[k+1])
      );
    end
  end

  // next index, entry key XOR and exit key XOR
  always_comb begin
    idx_nx  = {1'b0, idx_q} + 5'(UNROLL);
    last    = (idx_nx >= 5'(MAX_ROUND));
    load_st = state_i;
    if (mode_i == PM_FINAL) begin
      load_st.x1 = state_i.x1 ^ key_i[127:64];
      load_st.x2 = state_i.x2 ^ key_i[63:0];
    end
    busy_st = stg[UNROLL];
    if (last && (mode_q != PM_PLAIN)) begin
      busy_st.x3 = stg[UNROLL].x3 ^ key_q[127:64];
      busy_st.x4 = stg[UNROLL].x4 ^ key_q[63:0];
    end
  end

  // control FSM with registered done/err pulses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q    <= FSM_IDLE;
      idx_q    <= '0;
      mode_q   <= PM_PLAIN;
      key_q    <= '0;
      work_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= IRQ_EN_RST;
    end else begin
      irq_en_q <= irq_en_i;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      unique case (fsm_q)
        FSM_IDLE: begin
          if (start_i) begin
            if (legal_rounds(rounds_i)) begin
              fsm_q  <= FSM_BUSY;
              idx_q  <= 4'(MAX_ROUND) - rounds_i;
              mode_q <= mode_i;
              key_q  <= key_i;
              work_q <= load_st;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FSM_BUSY: begin
          if (abort_i) begin
            fsm_q <= FSM_IDLE;
          end else begin
            work_q <= busy_st;
            idx_q  <= idx_nx[3:0];
            if (last) begin
              fsm_q  <= FSM_IDLE;
              done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign ready_o        = !busy;
  assign update_state_o = busy && !abort_i;
  assign state_o        = busy ? busy_st : work_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign ascon_intr_o   = done_q && irq_en_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: UNROLL=1 and UNROLL=3 instances checked
// every cycle against a round-count model of the Ascon permutation.
module tb_ascon_perm_ctrl;
  import reg_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start;
  logic [3:0]   rounds;
  perm_mode_t   mode;
  logic [127:0] key;
  logic         abort;
  logic         irq_en;
  state_t       st_in;
  reg_req_t     req;

  logic     rdy [2];
  logic     upd [2];
  logic     dn [2];
  logic     intr [2];
  logic     er [2];
  state_t   so [2];
  reg_rsp_t rsp [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ascon_perm_ctrl #(.UNROLL(1), .IRQ_EN_RST(1'b1)) u_dut1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .sbox_reg_req_i(req), .sbox_reg_rsp_o(rsp[0]),
    .start_i(start), .ready_o(rdy[0]), .rounds_i(rounds),
    .mode_i(mode), .key_i(key), .abort_i(abort), .irq_en_i(irq_en),
    .state_i(st_in), .state_o(so[0]), .update_state_o(upd[0]),
    .done_o(dn[0]), .ascon_intr_o(intr[0]), .err_o(er[0])
  );

  ascon_perm_ctrl #(.UNROLL(3), .IRQ_EN_RST(1'b1)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .sbox_reg_req_i(req), .sbox_reg_rsp_o(rsp[1]),
    .start_i(start), .ready_o(rdy[1]), .rounds_i(rounds),
    .mode_i(mode), .key_i(key), .abort_i(abort), .irq_en_i(irq_en),
    .state_i(st_in), .state_o(so[1]), .update_state_o(upd[1]),
    .done_o(dn[1]), .ascon_intr_o(intr[1]), .err_o(er[1])
  );

  logic [4:0] SB [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  // ---------------- reference permutation ----------------
  function automatic logic [63:0] rr(logic [63:0] x, int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic int rc(int r);
    return ((15 - r) << 4) | r;
  endfunction

  function automatic state_t sbox_bs(state_t s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s.x0; x1 = s.x1; x2 = s.x2; x3 = s.x3; x4 = s.x4;
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3;
    t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    return '{x0, x1, x2, x3, x4};
  endfunction

  function automatic state_t lin(state_t s);
    state_t r;
    r.x0 = s.x0 ^ rr(s.x0, 19) ^ rr(s.x0, 28);
    r.x1 = s.x1 ^ rr(s.x1, 61) ^ rr(s.x1, 39);
    r.x2 = s.x2 ^ rr(s.x2, 1) ^ rr(s.x2, 6);
    r.x3 = s.x3 ^ rr(s.x3, 10) ^ rr(s.x3, 17);
    r.x4 = s.x4 ^ rr(s.x4, 7) ^ rr(s.x4, 41);
    return r;
  endfunction

  function automatic state_t perm(state_t s, int lo, int hi);
    state_t t = s;
    for (int r = lo; r < hi; r++) begin
      t.x2 = t.x2 ^ 64'(rc(r));
      t = lin(sbox_bs(t));
    end
    return t;
  endfunction

  // ---------------- transaction-level model ----------------
  bit           mb [2];
  state_t       ms0 [2];
  int           mn [2];
  int           mc [2];
  int           mtot [2];
  perm_mode_t   mm [2];
  logic [127:0] mk [2];
  state_t       mw [2];
  bit           mdone [2];
  bit           merr [2];
  bit           mirq;

  function automatic int uval(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic state_t exp_busy(int d);
    int lo, hi;
    state_t s;
    lo = 12 - mn[d];
    hi = lo + (mc[d] + 1) * uval(d);
    if (hi > 12) hi = 12;
    s = perm(ms0[d], lo, hi);
    if ((mc[d] + 1 == mtot[d]) && (mm[d] != PM_PLAIN)) begin
      s.x3 ^= mk[d][127:64];
      s.x4 ^= mk[d][63:0];
    end
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        mb[d] = 0; mw[d] = '0; mdone[d] = 0; merr[d] = 0; mc[d] = 0;
      end
      mirq = 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit nd, ne;
        state_t s;
        nd = 0; ne = 0;
        if (mb[d]) begin
          if (abort) mb[d] = 0;
          else begin
            mw[d] = exp_busy(d);
            mc[d]++;
            if (mc[d] == mtot[d]) begin mb[d] = 0; nd = 1; end
          end
        end else if (start) begin
          if (rounds == 6 || rounds == 8 || rounds == 12) begin
            s = st_in;
            if (mode == PM_FINAL) begin
              s.x1 ^= key[127:64];
              s.x2 ^= key[63:0];
            end
            mb[d] = 1; mn[d] = int'(rounds); mm[d] = mode; mk[d] = key;
            ms0[d] = s; mw[d] = s; mc[d] = 0;
            mtot[d] = (mn[d] + uval(d) - 1) / uval(d);
          end else ne = 1;
        end
        mdone[d] = nd;
        merr[d] = ne;
      end
      mirq = irq_en;
    end
  end

  // ---------------- checkers ----------------
  task automatic chk_b(string nm, int d, logic a, logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s dut%0d got=%0b exp=%0b t=%0t", nm, d, a, e, $time);
    end
  endtask

  task automatic chk_i(string nm, int d, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s idx%0d got=%0d exp=%0d t=%0t", nm, d, a, e, $time);
    end
  endtask

  task automatic chk_s(string nm, int d, state_t a, state_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, d, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk_b("ready", d, rdy[d], !mb[d]);
      chk_b("update", d, upd[d], mb[d] && !abort);
      chk_b("done", d, dn[d], mdone[d]);
      chk_b("err", d, er[d], merr[d]);
      chk_b("intr", d, intr[d], mdone[d] && mirq);
      chk_s("state", d, so[d], mb[d] ? exp_busy(d) : mw[d]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!(rdy[0] && rdy[1]) && w < 60) begin tick(); w++; end
    chk_b("ready_wait", 0, rdy[0] && rdy[1], 1'b1);
  endtask

  task automatic issue(int n, perm_mode_t m, logic [127:0] k, state_t s);
    rounds = 4'(n); mode = m; key = k; st_in = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int isn [2];

  task automatic run_lat(int n, perm_mode_t m, logic [127:0] k, state_t s);
    int lat [2];
    wait_ready();
    issue(n, m, k, s);
    lat[0] = -1; lat[1] = -1; isn[0] = 0; isn[1] = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if (lat[d] < 0 && dn[d]) lat[d] = c;
        if (intr[d]) isn[d]++;
      end
      if (lat[0] > 0 && lat[1] > 0) break;
    end
    for (int d = 0; d < 2; d++)
      chk_i("latency", d, lat[d], (n + uval(d) - 1) / uval(d));
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    state_t ivs, o, s;
    logic [127:0] k0;
    int seen, v;
    int rtab [9] = '{6, 8, 12, 6, 8, 12, 7, 0, 15};
    start = 0; rounds = 4'd12; mode = PM_PLAIN; key = '0; abort = 0;
    irq_en = 1; st_in = '0; req = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk_b("rst_ready", d, rdy[d], 1'b1);
      chk_b("rst_done", d, dn[d], 1'b0);
      chk_s("rst_state", d, so[d], '0);
    end
    rst_n = 1'b1;
    tick();

    chk_i("rc0", 0, rc(0), 'hf0);
    chk_i("rc6", 6, rc(6), 'h96);
    chk_i("rc10", 10, rc(10), 'h5a);
    chk_i("rc11", 11, rc(11), 'h4b);
    for (int i = 0; i < 32; i++) begin
      s = '0;
      s.x0[0] = i[4]; s.x1[0] = i[3]; s.x2[0] = i[2];
      s.x3[0] = i[1]; s.x4[0] = i[0];
      o = sbox_bs(s);
      v = int'({o.x0[0], o.x1[0], o.x2[0], o.x3[0], o.x4[0]});
      chk_i("model_sbox", i, v, int'(SB[i]));
    end

    for (int i = 0; i < 32; i++) begin
      req.valid = 1'b1; req.write = 1'b0; req.addr = 8'(i);
      #1;
      chk_i("lut_read", i, int'(rsp[0].rdata), int'(SB[i]));
    end
    req.addr = 8'd5; req.write = 1'b1; req.wdata = 5'h1e;
    tick();
    req.write = 1'b0;
    #1 chk_i("lut_write", 5, int'(rsp[0].rdata), 'h1e);
    req.write = 1'b1; req.wdata = SB[5];
    tick();
    req.write = 1'b0;
    #1 chk_i("lut_restore", 5, int'(rsp[0].rdata), int'(SB[5]));
    req.addr = 8'h40;
    #1 chk_b("lut_err", 0, rsp[0].error, 1'b1);
    req = '0;

    k0 = 128'h000102030405060708090a0b0c0d0e0f;
    ivs = '{64'h80400c0600000000, k0[127:64], k0[63:0],
            64'h1011121314151617, 64'h18191a1b1c1d1e1f};
    run_lat(12, PM_PLAIN, k0, ivs);
    run_lat(8, PM_PLAIN, k0, ivs);
    run_lat(6, PM_INIT, k0, ivs);
    run_lat(12, PM_FINAL, k0, ivs);

    wait_ready();
    issue(12, PM_PLAIN, k0, ivs);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_b("abort_idle", 0, rdy[0], 1'b1);
    seen = 0;
    repeat (20) begin tick(); seen += int'(dn[0] | intr[0]); end
    chk_i("abort_nodone", 0, seen, 0);
    run_lat(12, PM_INIT, k0, ivs);

    wait_ready();
    issue(7, PM_PLAIN, k0, ivs);
    for (int d = 0; d < 2; d++) begin
      chk_b("rej_err", d, er[d], 1'b1);
      chk_b("rej_ready", d, rdy[d], 1'b1);
      chk_b("rej_upd", d, upd[d], 1'b0);
    end

    irq_en = 1'b0;
    run_lat(8, PM_FINAL, k0, ivs);
    chk_i("irq_off", 0, isn[0], 0);
    irq_en = 1'b1;

    wait_ready();
    issue(12, PM_PLAIN, k0, ivs);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_b("mrst_upd", d, upd[d], 1'b0);
      chk_b("mrst_ready", d, rdy[d], 1'b1);
      chk_s("mrst_state", d, so[d], '0);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    #1 chk_b("rel_ready", 0, rdy[0], 1'b1);
    seen = 0;
    repeat (15) begin tick(); seen += int'(dn[0] | dn[1]); end
    chk_i("mrst_nodone", 0, seen, 0);

    for (int c = 0; c < 800; c++) begin
      start = ($urandom % 3) == 0;
      rounds = 4'(rtab[$urandom % 9]);
      mode = perm_mode_t'($urandom % 3);
      key = {r64(), r64()};
      st_in = '{r64(), r64(), r64(), r64(), r64()};
      abort = ($urandom % 16) == 0;
      irq_en = ($urandom % 4) != 0;
      tick();
    end
    start = 0; abort = 0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
